// File: rtl/mips_cpu_regfile_mp.sv
// Multi-read-port MIPS register file with registered write-back stage, partial-load merge and load scoreboard.
// Define REGFILE_BYPASS_EN to forward the write-back stage to reads and regv0 (1-cycle visibility).
module mips_cpu_regfile_mp #(
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_RD*AW-1:0] rd_addr,
  output logic [NUM_RD*32-1:0] rd_data,
  output logic [NUM_RD-1:0]    rd_busy,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [31:0]          wr_data,
  input  logic [5:0]           wr_opcode,
  input  logic [1:0]           wr_vaddr,
  input  logic                 ld_issue,
  input  logic [AW-1:0]        ld_issue_reg,
  output logic                 wr_err,
  output logic [31:0]          regv0
);

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LWL = 6'b100010;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LWR = 6'b100110;

  logic [31:0]         regs [NUM_REGS];
  logic                stage_valid;
  logic [AW-1:0]       stage_addr;
  logic [31:0]         stage_data;
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_next;

  logic [31:0] old_val;
  logic [31:0] merged;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        misaligned;
  logic        is_load;
  logic        do_write;
  logic        capture;

  // The merge always sees the in-flight stage value so back-to-back partial loads compose.
  assign old_val  = (stage_valid && stage_addr == wr_addr) ? stage_data : regs[wr_addr];
  assign byte_sel = wr_data[{wr_vaddr, 3'b000} +: 8];
  assign half_sel = wr_vaddr[1] ? wr_data[31:16] : wr_data[15:0];
  assign is_load  = (wr_opcode >= OP_LB) && (wr_opcode <= OP_LWR);
  assign do_write = wr_en && (wr_addr != '0);
  assign capture  = do_write && !misaligned;

  always_comb begin
    merged     = wr_data;
    misaligned = 1'b0;
    case (wr_opcode)
      OP_LB:  merged = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU: merged = {24'h0, byte_sel};
      OP_LH: begin
        merged     = {{16{half_sel[15]}}, half_sel};
        misaligned = wr_vaddr[0];
      end
      OP_LHU: begin
        merged     = {16'h0, half_sel};
        misaligned = wr_vaddr[0];
      end
      OP_LWL: begin
        case (wr_vaddr)
          2'b00:   merged = {wr_data[7:0],  old_val[23:0]};
          2'b01:   merged = {wr_data[15:0], old_val[15:0]};
          2'b10:   merged = {wr_data[23:0], old_val[7:0]};
          default: merged = wr_data;
        endcase
      end
      OP_LWR: begin
        case (wr_vaddr)
          2'b00:   merged = wr_data;
          2'b01:   merged = {old_val[31:24], wr_data[31:8]};
          2'b10:   merged = {old_val[31:16], wr_data[31:16]};
          default: merged = {old_val[31:8],  wr_data[31:24]};
        endcase
      end
      default: merged = wr_data;
    endcase
  end

  // A new load issue to the same register outranks the completing load.
  always_comb begin
    busy_next = busy;
    if (do_write && is_load)
      busy_next[wr_addr] = 1'b0;
    if (ld_issue && ld_issue_reg != '0)
      busy_next[ld_issue_reg] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage_valid <= 1'b0;
      stage_addr  <= '0;
      stage_data  <= '0;
      wr_err      <= 1'b0;
      busy        <= '0;
    end else begin
      stage_valid <= capture;
      if (capture) begin
        stage_addr <= wr_addr;
        stage_data <= merged;
      end
      wr_err <= do_write && misaligned;
      busy   <= busy_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
    end else if (stage_valid) begin
      regs[stage_addr] <= stage_data;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0] sel;
    assign sel = rd_addr[k*AW +: AW];
`ifdef REGFILE_BYPASS_EN
    assign rd_data[k*32 +: 32] = (sel == '0) ? 32'h0 :
                                 (stage_valid && stage_addr == sel) ? stage_data : regs[sel];
    assign rd_busy[k] = busy[sel];
`else
    assign rd_data[k*32 +: 32] = (sel == '0) ? 32'h0 : regs[sel];
    assign rd_busy[k] = busy[sel] | (stage_valid && stage_addr == sel);
`endif
  end

  if (NUM_REGS > 2) begin : g_v0
`ifdef REGFILE_BYPASS_EN
    assign regv0 = (stage_valid && stage_addr == AW'(2)) ? stage_data : regs[2];
`else
    assign regv0 = regs[2];
`endif
  end else begin : g_no_v0
    assign regv0 = 32'h0;
  end

endmodule

// File: tb/tb_mips_cpu_regfile_mp.sv
// Directed self-checking bench for mips_cpu_regfile_mp (default 32 regs, 2 read ports).
module tb_mips_cpu_regfile_mp;

  localparam logic [5:0] OP_ADD = 6'b000000;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LWL = 6'b100010;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LWR = 6'b100110;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [5:0]  wr_opcode;
  logic [1:0]  wr_vaddr;
  logic        ld_issue;
  logic [4:0]  ld_issue_reg;
  logic        wr_err;
  logic [31:0] regv0;

  int n_cmp = 0;
  int n_bad = 0;

  mips_cpu_regfile_mp #(.NUM_REGS(32), .NUM_RD(2)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_opcode(wr_opcode),
    .wr_vaddr(wr_vaddr), .ld_issue(ld_issue), .ld_issue_reg(ld_issue_reg),
    .wr_err(wr_err), .regv0(regv0)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d,
                           input logic [5:0] op, input logic [1:0] v);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_opcode = op; wr_vaddr = v;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
    rd_addr = {a1, a0};
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    set_rd(5'd2, 5'd31);
    n_cmp++; if (rd_data !== 64'h0) begin n_bad++; $display("[TB] FAIL reset_rd_data: got %h want %h", rd_data, 64'h0); end
    n_cmp++; if (rd_busy !== 2'b00) begin n_bad++; $display("[TB] FAIL reset_rd_busy: got %b want %b", rd_busy, 2'b00); end
    n_cmp++; if (regv0 !== 32'h0) begin n_bad++; $display("[TB] FAIL reset_regv0: got %h want %h", regv0, 32'h0); end
    n_cmp++; if (wr_err !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_wr_err: got %b want %b", wr_err, 1'b0); end
    @(posedge clk);
    #1 rst = 1'b1;
    tick();
  endtask

  task automatic test_write();
    write_reg(5'd5, 32'hDEADBEEF, OP_ADD, 2'b00);
    tick();
    set_rd(5'd5, 5'd0);
    n_cmp++; if (rd_data[31:0] !== 32'hDEADBEEF) begin n_bad++; $display("[TB] FAIL write_r5: got %h want %h", rd_data[31:0], 32'hDEADBEEF); end
    n_cmp++; if (rd_data[63:32] !== 32'h0) begin n_bad++; $display("[TB] FAIL read_r0: got %h want %h", rd_data[63:32], 32'h0); end
    write_reg(5'd0, 32'h00001234, OP_ADD, 2'b00);
    n_cmp++; if (wr_err !== 1'b0) begin n_bad++; $display("[TB] FAIL write_r0_err: got %b want %b", wr_err, 1'b0); end
    tick();
    set_rd(5'd0, 5'd5);
    n_cmp++; if (rd_data !== {32'hDEADBEEF, 32'h0}) begin n_bad++; $display("[TB] FAIL write_r0_read: got %h want %h", rd_data, {32'hDEADBEEF, 32'h0}); end
    write_reg(5'd2, 32'hCAFEF00D, OP_ADD, 2'b00);
    tick();
    set_rd(5'd5, 5'd2);
    n_cmp++; if (regv0 !== 32'hCAFEF00D) begin n_bad++; $display("[TB] FAIL regv0: got %h want %h", regv0, 32'hCAFEF00D); end
    n_cmp++; if (rd_data !== {32'hCAFEF00D, 32'hDEADBEEF}) begin n_bad++; $display("[TB] FAIL two_ports: got %h want %h", rd_data, {32'hCAFEF00D, 32'hDEADBEEF}); end
  endtask

  task automatic test_latency();
    logic [31:0] exp_d;
    logic        exp_b;
`ifdef REGFILE_BYPASS_EN
    exp_d = 32'h0000600D; exp_b = 1'b0;
`else
    exp_d = 32'h0; exp_b = 1'b1;
`endif
    write_reg(5'd6, 32'h0000600D, OP_ADD, 2'b00);
    set_rd(5'd6, 5'd0);
    n_cmp++; if (rd_data[31:0] !== exp_d) begin n_bad++; $display("[TB] FAIL stage_read: got %h want %h", rd_data[31:0], exp_d); end
    n_cmp++; if (rd_busy[0] !== exp_b) begin n_bad++; $display("[TB] FAIL stage_busy: got %b want %b", rd_busy[0], exp_b); end
    tick();
    n_cmp++; if (rd_data[31:0] !== 32'h0000600D) begin n_bad++; $display("[TB] FAIL commit_read: got %h want %h", rd_data[31:0], 32'h0000600D); end
    n_cmp++; if (rd_busy[0] !== 1'b0) begin n_bad++; $display("[TB] FAIL commit_busy: got %b want %b", rd_busy[0], 1'b0); end
  endtask

  task automatic test_partial();
    set_rd(5'd7, 5'd0);
    write_reg(5'd7, 32'h11223344, OP_ADD, 2'b00); tick();
    n_cmp++; if (rd_data[31:0] !== 32'h11223344) begin n_bad++; $display("[TB] FAIL r7_init: got %h want %h", rd_data[31:0], 32'h11223344); end
    write_reg(5'd7, 32'h80FF7F01, OP_LB, 2'b11); tick();
    n_cmp++; if (rd_data[31:0] !== 32'hFFFFFF80) begin n_bad++; $display("[TB] FAIL lb_b3: got %h want %h", rd_data[31:0], 32'hFFFFFF80); end
    write_reg(5'd7, 32'h80FF7F01, OP_LBU, 2'b01); tick();
    n_cmp++; if (rd_data[31:0] !== 32'h0000007F) begin n_bad++; $display("[TB] FAIL lbu_b1: got %h want %h", rd_data[31:0], 32'h0000007F); end
    write_reg(5'd7, 32'h80FF7F01, OP_LH, 2'b10); tick();
    n_cmp++; if (rd_data[31:0] !== 32'hFFFF80FF) begin n_bad++; $display("[TB] FAIL lh_b2: got %h want %h", rd_data[31:0], 32'hFFFF80FF); end
    write_reg(5'd7, 32'h80FF7F01, OP_LH, 2'b01);
    n_cmp++; if (wr_err !== 1'b1) begin n_bad++; $display("[TB] FAIL lh_odd_err: got %b want %b", wr_err, 1'b1); end
    tick();
    n_cmp++; if (wr_err !== 1'b0) begin n_bad++; $display("[TB] FAIL lh_odd_err_clear: got %b want %b", wr_err, 1'b0); end
    n_cmp++; if (rd_data[31:0] !== 32'hFFFF80FF) begin n_bad++; $display("[TB] FAIL lh_odd_keep: got %h want %h", rd_data[31:0], 32'hFFFF80FF); end
    write_reg(5'd7, 32'h1234ABCD, OP_LHU, 2'b00); tick();
    n_cmp++; if (rd_data[31:0] !== 32'h0000ABCD) begin n_bad++; $display("[TB] FAIL lhu_b0: got %h want %h", rd_data[31:0], 32'h0000ABCD); end
    write_reg(5'd7, 32'hEE000000, OP_LWR, 2'b11); tick();
    n_cmp++; if (rd_data[31:0] !== 32'h0000ABEE) begin n_bad++; $display("[TB] FAIL lwr_b3: got %h want %h", rd_data[31:0], 32'h0000ABEE); end
  endtask

  task automatic test_back_to_back();
    set_rd(5'd3, 5'd0);
    write_reg(5'd3, 32'hAABBCCDD, OP_ADD, 2'b00); tick();
    n_cmp++; if (rd_data[31:0] !== 32'hAABBCCDD) begin n_bad++; $display("[TB] FAIL r3_init: got %h want %h", rd_data[31:0], 32'hAABBCCDD); end
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h11223344; wr_opcode = OP_LWL; wr_vaddr = 2'b01;
    tick();
    wr_data = 32'h55667788; wr_opcode = OP_LWR; wr_vaddr = 2'b10;
    tick();
    wr_en = 1'b0;
    tick();
    n_cmp++; if (rd_data[31:0] !== 32'h33445566) begin n_bad++; $display("[TB] FAIL lwl_lwr_b2b: got %h want %h", rd_data[31:0], 32'h33445566); end
    write_reg(5'd3, 32'h000000AB, OP_LWL, 2'b00); tick();
    n_cmp++; if (rd_data[31:0] !== 32'hAB445566) begin n_bad++; $display("[TB] FAIL lwl_b0: got %h want %h", rd_data[31:0], 32'hAB445566); end
  endtask

  task automatic test_scoreboard();
    set_rd(5'd9, 5'd10);
    ld_issue = 1'b1; ld_issue_reg = 5'd9;
    tick();
    ld_issue = 1'b0;
    n_cmp++; if (rd_busy !== 2'b01) begin n_bad++; $display("[TB] FAIL busy_set: got %b want %b", rd_busy, 2'b01); end
    write_reg(5'd9, 32'h00000099, OP_LW, 2'b00); tick();
    n_cmp++; if (rd_busy !== 2'b00) begin n_bad++; $display("[TB] FAIL busy_clear: got %b want %b", rd_busy, 2'b00); end
    n_cmp++; if (rd_data[31:0] !== 32'h00000099) begin n_bad++; $display("[TB] FAIL lw_data: got %h want %h", rd_data[31:0], 32'h00000099); end
    ld_issue = 1'b1; ld_issue_reg = 5'd9;
    write_reg(5'd9, 32'h00000042, OP_LW, 2'b00);
    ld_issue = 1'b0;
    tick();
    n_cmp++; if (rd_busy[0] !== 1'b1) begin n_bad++; $display("[TB] FAIL busy_set_wins: got %b want %b", rd_busy[0], 1'b1); end
    write_reg(5'd9, 32'hFFFFFFFF, OP_LH, 2'b01); tick();
    n_cmp++; if (rd_busy[0] !== 1'b0) begin n_bad++; $display("[TB] FAIL busy_clear_misaligned: got %b want %b", rd_busy[0], 1'b0); end
    n_cmp++; if (rd_data[31:0] !== 32'h00000042) begin n_bad++; $display("[TB] FAIL misaligned_keep: got %h want %h", rd_data[31:0], 32'h00000042); end
    ld_issue = 1'b1; ld_issue_reg = 5'd10;
    tick();
    ld_issue_reg = 5'd0;
    tick();
    ld_issue = 1'b0;
    write_reg(5'd10, 32'h00000010, OP_ADD, 2'b00); tick();
    set_rd(5'd0, 5'd10);
    n_cmp++; if (rd_busy !== 2'b10) begin n_bad++; $display("[TB] FAIL busy_nonload_r0: got %b want %b", rd_busy, 2'b10); end
  endtask

  task automatic test_reset_mid();
    ld_issue = 1'b1; ld_issue_reg = 5'd12;
    write_reg(5'd4, 32'h00000005, OP_ADD, 2'b00);
    ld_issue = 1'b0;
    #2 rst = 1'b0;
    #2 rst = 1'b1;
    tick();
    set_rd(5'd4, 5'd12);
    n_cmp++; if (rd_data !== 64'h0) begin n_bad++; $display("[TB] FAIL reset_mid_data: got %h want %h", rd_data, 64'h0); end
    n_cmp++; if (rd_busy !== 2'b00) begin n_bad++; $display("[TB] FAIL reset_mid_busy: got %b want %b", rd_busy, 2'b00); end
    n_cmp++; if (regv0 !== 32'h0) begin n_bad++; $display("[TB] FAIL reset_mid_regv0: got %h want %h", regv0, 32'h0); end
    set_rd(5'd5, 5'd3);
    n_cmp++; if (rd_data !== 64'h0) begin n_bad++; $display("[TB] FAIL reset_mid_others: got %h want %h", rd_data, 64'h0); end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    wr_opcode = '0; wr_vaddr = '0; ld_issue = 1'b0; ld_issue_reg = '0;
    test_reset();
    test_write();
    test_latency();
    test_partial();
    test_back_to_back();
    test_scoreboard();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
